// File: rtl/bus_demux_4_pkg.sv
// Shared core types for the memory-path request demux: data width, target count
// and the demux FSM encoding.
package riscv_pkg;
  localparam int XLEN    = 32;
  localparam int NUM_TGT = 4;
  localparam int BE_W    = XLEN/8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} demux_state_e;
endpackage

// File: rtl/bus_demux_4_if.sv
// Core-side request/response and per-target bus signals of the 1:4 demux.
// slave = the demux itself, master = the core plus targets around it.
interface bus_demux_4_if;
  import riscv_pkg::*;

  logic                            req_valid_i;
  logic                            req_ready_o;
  logic [XLEN-1:0]                 req_addr_i;
  logic                            req_we_i;
  logic [XLEN-1:0]                 req_wdata_i;
  logic [BE_W-1:0]                 req_be_i;
  logic                            resp_valid_o;
  logic [XLEN-1:0]                 resp_rdata_o;
  logic                            resp_err_o;
  logic [NUM_TGT-1:0]              tgt_req_valid_o;
  logic [NUM_TGT-1:0]              tgt_req_ready_i;
  logic [XLEN-1:0]                 tgt_addr_o;
  logic [XLEN-1:0]                 tgt_wdata_o;
  logic                            tgt_we_o;
  logic [BE_W-1:0]                 tgt_be_o;
  logic [NUM_TGT-1:0]              tgt_resp_valid_i;
  logic [NUM_TGT-1:0][XLEN-1:0]    tgt_resp_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
           tgt_req_ready_i, tgt_resp_valid_i, tgt_resp_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           tgt_req_valid_o, tgt_addr_o, tgt_wdata_o, tgt_we_o, tgt_be_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
           tgt_req_ready_i, tgt_resp_valid_i, tgt_resp_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           tgt_req_valid_o, tgt_addr_o, tgt_wdata_o, tgt_we_o, tgt_be_o
  );
endinterface

// File: rtl/bus_demux_4_decode.sv
// Address region decoder: per-region masked compare, lowest matching index wins.
module addr_region_decode import riscv_pkg::*; (
  input  logic [XLEN-1:0]              addr_i,
  input  logic [NUM_TGT-1:0][XLEN-1:0] base_i,
  input  logic [NUM_TGT-1:0][XLEN-1:0] mask_i,
  output logic                         hit_o,
  output logic [1:0]                   sel_o
);
  logic [NUM_TGT-1:0] match;

  for (genvar k = 0; k < NUM_TGT; k++) begin : g_match
    assign match[k] = ((addr_i & mask_i[k]) == (base_i[k] & mask_i[k]));
  end

  // Walk downwards so the lowest matching region overrides any higher one.
  always_comb begin
    hit_o = |match;
    sel_o = '0;
    for (int k = NUM_TGT-1; k >= 0; k--) begin
      if (match[k]) sel_o = 2'(k);
    end
  end
endmodule

// File: rtl/bus_demux_4.sv
// Single-outstanding 1:4 request router: latches one core request, forwards it to
// the decoded target, returns its response or an error on no-hit / timeout.
module bus_demux_4 import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] BASE0   = 32'h0000_0000,
  parameter logic [XLEN-1:0] BASE1   = 32'h1000_0000,
  parameter logic [XLEN-1:0] BASE2   = 32'h2000_0000,
  parameter logic [XLEN-1:0] BASE3   = 32'h3000_0000,
  parameter logic [XLEN-1:0] MASK0   = 32'hF000_0000,
  parameter logic [XLEN-1:0] MASK1   = 32'hF000_0000,
  parameter logic [XLEN-1:0] MASK2   = 32'hF000_0000,
  parameter logic [XLEN-1:0] MASK3   = 32'hF000_0000,
  parameter int              TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bus_demux_4_if.slave  bus
);
  localparam int              CNT_W   = $clog2(TIMEOUT+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT-1);

  demux_state_e    state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic            we_q, we_d, err_q, err_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_TGT-1:0][XLEN-1:0] bases, masks;
  logic            dec_hit;
  logic [1:0]      dec_sel;
  logic            sel_rdy, sel_rsp, timed_out;

  assign bases = {BASE3, BASE2, BASE1, BASE0};
  assign masks = {MASK3, MASK2, MASK1, MASK0};

  addr_region_decode u_decode (
    .addr_i (bus.req_addr_i),
    .base_i (bases),
    .mask_i (masks),
    .hit_o  (dec_hit),
    .sel_o  (dec_sel)
  );

  assign sel_rdy   = bus.tgt_req_ready_i[sel_q];
  assign sel_rsp   = bus.tgt_resp_valid_i[sel_q];
  assign timed_out = (cnt_q >= TO_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if ((state_q == REQ || state_q == WAIT) && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          we_d    = bus.req_we_i;
          be_d    = bus.req_be_i;
          cnt_d   = '0;
          if (dec_hit) begin
            sel_d   = dec_sel;
            state_d = REQ;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      // A real response is checked before the timeout so it wins a same-cycle tie.
      REQ: begin
        if (sel_rdy && sel_rsp) begin
          rdata_d = bus.tgt_resp_rdata_i[sel_q];
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (sel_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sel_rsp) begin
          rdata_d = bus.tgt_resp_rdata_i[sel_q];
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.tgt_req_valid_o = '0;
    if (state_q == REQ) bus.tgt_req_valid_o[sel_q] = 1'b1;
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.resp_valid_o = (state_q == RESP);
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;
  assign bus.tgt_addr_o   = addr_q;
  assign bus.tgt_wdata_o  = wdata_q;
  assign bus.tgt_we_o     = we_q;
  assign bus.tgt_be_o     = be_q;
endmodule

// File: tb/tb_bus_demux_4.sv
// Bench for bus_demux_4: directed vector table, reset-in-WAIT sequence and
// randomized transactions checked against a region/latency reference model.
module tb_bus_demux_4;
  import riscv_pkg::*;

  localparam int TO = 64;
  // Region 3 overlaps region 2 (2xxx_xxxx) so lowest-index priority is exercised.
  localparam logic [NUM_TGT-1:0][XLEN-1:0] BASES =
    {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NUM_TGT-1:0][XLEN-1:0] MASKS =
    {32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_demux_4_if bus();

  bus_demux_4 #(
    .BASE0(BASES[0]), .BASE1(BASES[1]), .BASE2(BASES[2]), .BASE3(BASES[3]),
    .MASK0(MASKS[0]), .MASK1(MASKS[1]), .MASK2(MASKS[2]), .MASK3(MASKS[3]),
    .TIMEOUT(TO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          rdy_dly;   // cycles of valid before ready (>= TO means never)
    int          rsp_dly;   // cycles from handshake to response
    logic [31:0] rdata;
    bit          foreign;   // non-selected targets toggle ready/resp noise
    logic [3:0]  exp_tgt;
    int          exp_lat;   // response cycle counted from accept edge
    logic        exp_err;
    int          exp_vcyc;  // cycles tgt_req_valid_o is high
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ref_sel(input logic [31:0] a);
    for (int k = 0; k < NUM_TGT; k++)
      if ((a & MASKS[k]) == (BASES[k] & MASKS[k])) return k;
    return -1;
  endfunction

  // Latency model: handshake at cycle 1+rdy_dly, response rsp_dly later,
  // counter reaches TO-1 in cycle TO, so a response in cycle TO still counts.
  function automatic vec_t with_exp(input vec_t v);
    vec_t r = v;
    int s = ref_sel(v.addr);
    int h, c;
    if (s < 0) begin
      r.exp_tgt = 4'b0; r.exp_lat = 1; r.exp_err = 1'b1; r.exp_vcyc = 0;
    end else begin
      h = 1 + v.rdy_dly;
      c = h + v.rsp_dly;
      r.exp_tgt = 4'(1 << s);
      if (c <= TO) begin
        r.exp_lat = c + 1; r.exp_err = 1'b0; r.exp_vcyc = h;
      end else begin
        r.exp_lat = TO + 1; r.exp_err = 1'b1; r.exp_vcyc = (h < TO) ? h : TO;
      end
    end
    return r;
  endfunction

  task automatic clear_tgt();
    bus.tgt_req_ready_i  = '0;
    bus.tgt_resp_valid_i = '0;
    bus.tgt_resp_rdata_i = '0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int s, tcyc, hs, vcyc, lat, nresp, w;
    logic [3:0] seen, tv;
    logic [31:0] rd;
    logic er;
    bit stable_ok, rdy_ok;
    s = ref_sel(v.addr);
    tcyc = 0; hs = -1; vcyc = 0; lat = 0; nresp = 0;
    seen = '0; rd = '0; er = 1'b0; stable_ok = 1'b1; rdy_ok = 1'b1;
    w = 0;
    while (!bus.req_ready_o && w < 100) begin @(posedge clk); #1; w++; end
    chk({tag, " idle ready"}, {31'b0, bus.req_ready_o}, 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = v.addr;
    bus.req_we_i    = v.we;
    bus.req_wdata_i = v.wdata;
    bus.req_be_i    = v.be;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_we_i    = ~v.we;
    bus.req_wdata_i = $urandom;
    bus.req_be_i    = ~v.be;
    for (int c = 1; c <= 200; c++) begin
      tv = bus.tgt_req_valid_o;
      seen |= tv;
      if (tv != 0) begin
        vcyc++;
        if (bus.tgt_addr_o !== v.addr || bus.tgt_we_o !== v.we ||
            bus.tgt_wdata_o !== v.wdata || bus.tgt_be_o !== v.be) stable_ok = 1'b0;
      end
      if (lat == 0 && bus.req_ready_o) rdy_ok = 1'b0;
      if (lat != 0 && c == lat + 1 && !bus.req_ready_o) rdy_ok = 1'b0;
      if (bus.resp_valid_o) begin
        nresp++;
        if (lat == 0) begin lat = c; rd = bus.resp_rdata_o; er = bus.resp_err_o; end
      end
      clear_tgt();
      for (int k = 0; k < NUM_TGT; k++) begin
        bus.tgt_resp_rdata_i[k] = ~v.rdata;
        if (v.foreign && k != s) begin
          bus.tgt_req_ready_i[k]  = 1'($urandom_range(0, 1));
          bus.tgt_resp_valid_i[k] = 1'($urandom_range(0, 1));
        end
      end
      if (s >= 0) begin
        if (tv[s]) begin
          tcyc++;
          if (tcyc > v.rdy_dly) begin
            bus.tgt_req_ready_i[s] = 1'b1;
            if (hs < 0) hs = c;
          end
        end
        if (hs >= 0 && c == hs + v.rsp_dly) begin
          bus.tgt_resp_valid_i[s] = 1'b1;
          bus.tgt_resp_rdata_i[s] = v.rdata;
        end
      end
      if (lat != 0 && c >= lat + 3) break;
      @(posedge clk); #1;
    end
    clear_tgt();
    chk({tag, " tgt_valid set"}, {28'b0, seen}, {28'b0, v.exp_tgt});
    chk({tag, " valid cycles"}, vcyc, v.exp_vcyc);
    chk({tag, " resp latency"}, lat, v.exp_lat);
    chk({tag, " resp pulses"}, nresp, 1);
    chk({tag, " resp err"}, {31'b0, er}, {31'b0, v.exp_err});
    chk({tag, " resp rdata"}, rd, v.exp_err ? 32'h0 : v.rdata);
    chk({tag, " latched fields stable"}, {31'b0, stable_ok}, 32'd1);
    chk({tag, " req_ready timing"}, {31'b0, rdy_ok}, 32'd1);
  endtask

  vec_t vecs[11];
  vec_t rv;
  int   late_resp;

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_we_i    = 1'b0;
    bus.req_wdata_i = '0;
    bus.req_be_i    = '0;
    clear_tgt();

    //          addr          we    wdata          be       rdy   rsp   rdata          frn   tgt      lat err vcyc
    vecs[0]  = '{32'h1000_0004, 1'b0, 32'h0,         4'hF,    0,    0,    32'hDEAD_BEEF, 1'b0, 4'b0010,  2, 1'b0,  1};
    vecs[1]  = '{32'h3000_0010, 1'b1, 32'h1234_5678, 4'b0011, 3,    2,    32'h0000_00AA, 1'b0, 4'b1000,  7, 1'b0,  4};
    vecs[2]  = '{32'h5000_0000, 1'b0, 32'h0,         4'hF,    0,    0,    32'h1111_1111, 1'b0, 4'b0000,  1, 1'b1,  0};
    vecs[3]  = '{32'h2000_0000, 1'b0, 32'h0,         4'hF,    1000, 0,    32'h2222_2222, 1'b0, 4'b0100, 65, 1'b1, 64};
    vecs[4]  = '{32'h0000_0040, 1'b0, 32'h0,         4'hF,    0,    4,    32'hC0DE_0000, 1'b1, 4'b0001,  6, 1'b0,  1};
    vecs[5]  = '{32'h1FFF_FFFC, 1'b1, 32'hA5A5_A5A5, 4'b1000, 1,    0,    32'h3333_3333, 1'b0, 4'b0010,  3, 1'b0,  2};
    vecs[6]  = '{32'h0000_0000, 1'b0, 32'h0,         4'hF,    0,    63,   32'h4444_4444, 1'b0, 4'b0001, 65, 1'b0,  1};
    vecs[7]  = '{32'h0000_0000, 1'b0, 32'h0,         4'hF,    0,    64,   32'h5555_5555, 1'b0, 4'b0001, 65, 1'b1,  1};
    vecs[8]  = '{32'h2FFF_0000, 1'b1, 32'h0F0F_0F0F, 4'b0101, 2,    1,    32'h6666_6666, 1'b1, 4'b0100,  5, 1'b0,  3};
    vecs[9]  = '{32'h1000_0000, 1'b0, 32'h0,         4'hF,    63,   0,    32'h7777_7777, 1'b0, 4'b0010, 65, 1'b0, 64};
    vecs[10] = '{32'h1000_0000, 1'b0, 32'h0,         4'hF,    63,   1,    32'h8888_8888, 1'b0, 4'b0010, 65, 1'b1, 64};

    // Reset values while rst_n is still low.
    #2;
    chk("reset req_ready", {31'b0, bus.req_ready_o}, 32'd1);
    chk("reset resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    chk("reset tgt_req_valid", {28'b0, bus.tgt_req_valid_o}, 32'd0);
    chk("reset tgt_addr", bus.tgt_addr_o, 32'd0);
    chk("reset resp_err", {31'b0, bus.resp_err_o}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while the transaction sits in WAIT.
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0000_0ABC;
    bus.req_we_i    = 1'b1;
    bus.req_wdata_i = 32'hFFFF_0000;
    bus.req_be_i    = 4'hF;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.tgt_req_ready_i[0] = 1'b1;
    @(posedge clk); #1;
    clear_tgt();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst req_ready", {31'b0, bus.req_ready_o}, 32'd1);
    chk("async rst tgt_req_valid", {28'b0, bus.tgt_req_valid_o}, 32'd0);
    chk("async rst resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    chk("async rst tgt_addr", bus.tgt_addr_o, 32'd0);
    chk("async rst tgt_we", {31'b0, bus.tgt_we_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.tgt_resp_valid_i[0] = 1'b1;
    bus.tgt_resp_rdata_i[0] = 32'h5555_AAAA;
    late_resp = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      clear_tgt();
      if (bus.resp_valid_o) late_resp++;
    end
    chk("post-reset resp pulses", late_resp, 0);
    chk("post-reset resp_rdata", bus.resp_rdata_o, 32'd0);
    chk("post-reset req_ready", {31'b0, bus.req_ready_o}, 32'd1);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 4);
      rv = '{default: '0};
      rv.addr    = (r < 4) ? (BASES[r] | ($urandom & ~MASKS[r])) : $urandom;
      rv.we      = 1'($urandom_range(0, 1));
      rv.wdata   = $urandom;
      rv.be      = 4'($urandom_range(0, 15));
      rv.rdy_dly = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, 4);
      rv.rsp_dly = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(0, 4);
      rv.rdata   = $urandom;
      rv.foreign = 1'($urandom_range(0, 1));
      run_txn(with_exp(rv), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_demux_4.md
Name: bus_demux_4

Overview:
- Single-initiator to four-target request router for the multicycle core's memory path; the demultiplexing counterpart of the core's datapath select muxes.
- Accepts one load/store request and decodes its address against four parameterised regions. Forwards the request to the matching target with a valid/ready handshake, then returns that target's response to the core.
- Exactly one transaction outstanding. Unmapped addresses and unresponsive targets return an error response.

Parameters:
- BASE0..BASE3, defaults 32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000: region base addresses.
- MASK0..MASK3, default 32'hF000_0000 each: region compare masks.
- TIMEOUT, default 64: cycles allowed from entering REQ until the target response arrives.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  demux can accept a request.
- req_addr_i  in  XLEN  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_wdata_i  in  XLEN  store data.
- req_be_i  in  XLEN/8  byte enables.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  XLEN  load data.
- resp_err_o  out  1  response is an error.
- tgt_req_valid_o  out  4  per-target request valid, one-hot or zero.
- tgt_req_ready_i  in  4  per-target accept.
- tgt_addr_o, tgt_wdata_o  out  XLEN  latched request address and data, shared by all targets.
- tgt_we_o  out  1  latched write enable.
- tgt_be_o  out  XLEN/8  latched byte enables.
- tgt_resp_valid_i  in  4  per-target response valid.
- tgt_resp_rdata_i  in  4xXLEN  per-target read data.

Behaviour:
- Reset is asynchronous, active-low. While rst_ni=0:
  - state = IDLE; every output and internal register is 0, except req_ready_o = 1.
  - Reset mid-transaction abandons the transaction silently; no response is issued.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready_o = 1 only in IDLE.
  - On req_valid_i & req_ready_o (cycle N): latch addr, we, wdata and be; decode; clear the timeout counter.
  - Region k hits when (addr & MASKk) == (BASEk & MASKk). On multiple hits, the lowest k wins.
  - Any hit: sel = k, go to REQ. No hit: go to RESP with err = 1 and rdata = 0, so resp_valid_o is high at N+1.
- REQ:
  - tgt_req_valid_o[sel] = 1 from N+1; all other bits are 0. Latched fields are stable while valid is high.
  - On tgt_req_ready_i[sel]: drop valid next cycle.
  - If tgt_resp_valid_i[sel] is also high that cycle: capture the response, go to RESP. Otherwise go to WAIT.
- WAIT:
  - On tgt_resp_valid_i[sel]: capture tgt_resp_rdata_i[sel] into the response register with err = 0, go to RESP.
- Response timing: the response register drives resp_rdata_o and resp_err_o. resp_valid_o is high for exactly the one cycle spent in RESP. Best-case mapped latency: accept at N, response at N+2.
- Foreign inputs: tgt_req_ready_i and tgt_resp_valid_i bits for non-selected targets are ignored in every state. So are responses arriving in IDLE or RESP.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 with no response captured: drop tgt_req_valid_o, go to RESP with err = 1 and rdata = 0.
  - If a real response arrives in that same cycle, the real response wins.
- RESP always returns to IDLE. The next request can be accepted the cycle after resp_valid_o.
- The counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
- req_* inputs outside IDLE are don't-care. The core must hold them only until accepted.

Decomposition:
- riscv_pkg gains:
  - typedef enum logic [1:0] demux_state_e {IDLE, REQ, WAIT, RESP};
  - localparam int NUM_TGT = 4;
  - localparam int BE_W = XLEN/8.
- XLEN comes from riscv_pkg.
- One sub-module, addr_region_decode: combinational hit/priority encoder. Inputs are the address plus the bases and masks; outputs are hit and a 2-bit sel.
- FSM, latch registers and timeout live in the top.

Test Plan:
- Load addr 32'h1000_0004, target 1 ready at N+1 with resp_valid and rdata 32'hDEAD_BEEF in the same cycle -> tgt_req_valid_o = 4'b0010 at N+1 only; resp_valid_o at N+2 with rdata DEAD_BEEF, err 0; req_ready_o low N+1..N+2.
- Store addr 32'h3000_0010, wdata 32'h1234_5678, be 4'b0011; target 3 ready after 3 cycles, responds 2 cycles later -> tgt_we_o = 1 and tgt_be_o = 4'b0011 stable while valid; exactly one resp_valid_o pulse, err 0.
- Address 32'h5000_0000 -> no tgt_req_valid_o bit ever set; resp_valid_o at N+1 with err 1, rdata 0.
- Target 2 never readies, TIMEOUT = 64 -> tgt_req_valid_o[2] is high 64 cycles then drops; resp_valid_o with err 1; the next request is accepted the following cycle.
- Target 0 selected; targets 1 and 3 pulse resp_valid during WAIT -> ignored; only target 0's data is returned.
- rst_ni asserted in WAIT -> all outputs 0 and req_ready_o = 1 immediately (asynchronous); no resp_valid_o after release; a late target response is ignored.
